// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer: valid/ready parallel-to-serial front end with one-word holding buffer.
// Define SER_PARITY_EN to append an even-parity bit after each word's data bits.
module seq_bit_serializer #(
   parameter int   WIDTH     = 8,
   parameter bit   MSB_FIRST = 1'b1,
   parameter logic IDLE_BIT  = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             frame_start,
   output logic             busy
);
`ifdef SER_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST  = CW'(WIDTH - 1 + PAR);
   localparam logic [CW-1:0] DLAST = CW'(WIDTH - 1);
   typedef enum logic {IDLE, SHIFT} state_t;
   state_t state, state_n;
   logic [WIDTH-1:0] sr, sr_n, hb, hb_n, word;
   logic [CW-1:0] cnt, cnt_n;
   logic hb_full, hb_full_n, sout_n, sv_n, fs_n, par, par_n, xfer, take;
   assign din_ready = !hb_full;
   assign busy      = (state == SHIFT) || hb_full;
   assign xfer      = din_valid && din_ready;
   assign word      = hb_full ? hb : din;
   // a new word enters the shift register only when the line is free or the current frame ends now
   assign take      = en && (state == IDLE || cnt == LAST) && (hb_full || xfer);
   always_comb begin
      state_n   = state;
      sr_n      = sr;
      cnt_n     = cnt;
      hb_n      = hb;
      hb_full_n = hb_full;
      sout_n    = sout;
      sv_n      = sout_valid;
      fs_n      = 1'b0;
      par_n     = par;
      if (xfer && !take) begin
         hb_n      = din;
         hb_full_n = 1'b1;
      end
      if (take) begin
         state_n   = SHIFT;
         hb_full_n = 1'b0;
         sr_n      = MSB_FIRST ? word << 1 : word >> 1;
         sout_n    = MSB_FIRST ? word[WIDTH-1] : word[0];
         sv_n      = 1'b1;
         cnt_n     = '0;
         fs_n      = 1'b1;
         par_n     = ^word;
      end else if (en && state == SHIFT) begin
         if (cnt == LAST) begin
            state_n = IDLE;
            sout_n  = IDLE_BIT;
            sv_n    = 1'b0;
            cnt_n   = '0;
         end else if (cnt == DLAST) begin
            sout_n = par;
            cnt_n  = cnt + 1'b1;
         end else begin
            sout_n = MSB_FIRST ? sr[WIDTH-1] : sr[0];
            sr_n   = MSB_FIRST ? sr << 1 : sr >> 1;
            cnt_n  = cnt + 1'b1;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         sr          <= '0;
         cnt         <= '0;
         hb          <= '0;
         hb_full     <= 1'b0;
         sout        <= IDLE_BIT;
         sout_valid  <= 1'b0;
         frame_start <= 1'b0;
         par         <= 1'b0;
      end else begin
         state       <= state_n;
         sr          <= sr_n;
         cnt         <= cnt_n;
         hb          <= hb_n;
         hb_full     <= hb_full_n;
         sout        <= sout_n;
         sout_valid  <= sv_n;
         frame_start <= fs_n;
         par         <= par_n;
      end
   end
endmodule
